alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Sequencing controller that wraps the combinational arithmetic breadboard (add/sub/mul/div, 4-bit command, 32-bit result, 2-bit error). It accepts operation requests over a valid/ready handshake and registers the operands and command onto the ALU inputs. After a programmable settle interval it captures the ALU result and error, then holds them for a downstream consumer until that consumer accepts. It also keeps a result accumulator for chained operations and a saturating error counter.

## Interface
- SETTLE_CYCLES, 1: cycles the ALU inputs are held stable before capture; legal range 1..15, 0 is illegal.
- ERR_CNT_W, 8: width of the error counter.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_opA  in  16  operand A.
- req_opB  in  16  operand B.
- req_cmd  in  4  ALU command: 0 ground, 1 add, 2 sub, 3 mul, 4 div, 5 mod; 6..15 illegal.
- req_acc  in  1  when 1, acc[15:0] replaces req_opA.
- alu_inputA  out  16  registered operand A to the ALU.
- alu_inputB  out  16  registered operand B to the ALU.
- alu_command  out  4  registered command to the ALU.
- alu_result  in  32  ALU result.
- alu_error  in  2  ALU error: [1] divide-by-zero, [0] overflow.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  captured result.
- rsp_error  out  2  captured error.
- acc  out  32  last error-free accepted result.
- err_count  out  ERR_CNT_W  number of accepted responses with nonzero error; saturates.

## Operation
- States: IDLE, DRIVE, RESP. A settle counter cnt (4 bits) runs only in DRIVE.
- req_ready = (state == IDLE) and rst_n.
- IDLE, edge with req_valid and req_ready:
  - Legal cmd (0..5): alu_inputA <= req_acc ? acc[15:0] : req_opA; alu_inputB <= req_opB; alu_command <= req_cmd; cnt <= SETTLE_CYCLES; go to DRIVE.
  - Illegal cmd (6..15): alu_* registers unchanged; rsp_result <= 0; rsp_error <= 2'b11; rsp_valid <= 1; go to RESP.
- DRIVE, each edge:
  - cnt == 1: rsp_result <= alu_result; rsp_error <= alu_error; rsp_valid <= 1; go to RESP.
  - Otherwise cnt <= cnt - 1.
  - req_valid is ignored in DRIVE.
- RESP: rsp_result and rsp_error are held stable while rsp_valid=1 and rsp_ready=0. On the edge with rsp_ready=1:
  - rsp_valid <= 0; go to IDLE.
  - If rsp_error == 0, acc <= rsp_result.
  - If rsp_error != 0, err_count increments, saturating at all-ones.
- alu_* outputs keep their last values in IDLE and RESP. The ALU always sees stable inputs.
- acc is 32 bits, but only acc[15:0] is fed back. The upper bits are not checked.
- A divide-by-zero or overflow result is still delivered. It is never written to acc.

## Timing
- Reset (rst_n low at an edge): state IDLE, cnt 0, alu_inputA/alu_inputB/alu_command 0 (ground command), rsp_valid 0, rsp_result 0, rsp_error 0, acc 0, err_count 0.
- req_ready is 0 while rst_n is low and 1 in the first cycle after release.
- Reset mid-operation (DRIVE or RESP) abandons the operation. No response is produced, and acc and err_count are cleared.
- Latency, legal cmd: accept at edge E0; capture at edge E0+SETTLE_CYCLES; rsp_valid high after that edge.
- Latency, illegal cmd: rsp_valid high after E0.
- Throughput with rsp_ready tied high: one operation per SETTLE_CYCLES+2 cycles. req_ready returns one cycle after the response handshake.
- No combinational path from req_valid or rsp_ready to any output except req_ready, which depends on state and rst_n only.
- Response handshake and a new request cannot occur on the same edge.

## Test plan
- Add: A=249, B=0, cmd=1, SETTLE_CYCLES=1 -> rsp_valid 2 edges after accept; rsp_result=249, rsp_error=00; acc=249 after handshake.
- Divide by zero: A=249, B=0, cmd=4 -> rsp_error=10; acc unchanged; err_count=1 after handshake.
- Chain with overflow: acc=32000, then req_acc=1, B=8193, cmd=1 -> alu_inputA=32000; rsp_error=01; acc stays 32000; err_count increments.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_result and rsp_error constant, req_ready=0 throughout; handshake on cycle 6; req_ready=1 the next cycle.
- Illegal command: cmd=9 -> rsp_valid one edge after accept; rsp_result=0, rsp_error=11; alu_command keeps its previous value.
- Reset and saturation:
  - Assert rst_n=0 during DRIVE -> all outputs at reset values on the next cycle; no rsp_valid pulse.
  - With ERR_CNT_W=2, four error responses -> err_count=3.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: registers a request onto the ALU inputs,
// waits a settle interval, captures result/error and holds them until accepted.
module alu_issue_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned ERR_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [15:0]          req_opA,
   input  logic [15:0]          req_opB,
   input  logic [3:0]           req_cmd,
   input  logic                 req_acc,
   output logic [15:0]          alu_inputA,
   output logic [15:0]          alu_inputB,
   output logic [3:0]           alu_command,
   input  logic [31:0]          alu_result,
   input  logic [1:0]           alu_error,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_result,
   output logic [1:0]           rsp_error,
   output logic [31:0]          acc,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   localparam logic [3:0]           SETTLE_INIT = 4'(SETTLE_CYCLES);
   localparam logic [3:0]           CMD_MAX     = 4'd5;
   localparam logic [ERR_CNT_W-1:0] ERR_MAX     = {ERR_CNT_W{1'b1}};
   localparam logic [ERR_CNT_W-1:0] ERR_ONE     = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [15:0]          alu_a_q, alu_a_d;
   logic [15:0]          alu_b_q, alu_b_d;
   logic [3:0]           alu_cmd_q, alu_cmd_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [31:0]          rsp_result_q, rsp_result_d;
   logic [1:0]           rsp_error_q, rsp_error_d;
   logic [31:0]          acc_q, acc_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Next-state and datapath update for the IDLE/DRIVE/RESP sequence.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_cmd_d    = alu_cmd_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_error_d  = rsp_error_q;
      acc_d        = acc_q;
      err_cnt_d    = err_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_cmd <= CMD_MAX) begin
                  alu_a_d   = req_acc ? acc_q[15:0] : req_opA;
                  alu_b_d   = req_opB;
                  alu_cmd_d = req_cmd;
                  cnt_d     = SETTLE_INIT;
                  state_d   = ST_DRIVE;
               end else begin
                  // Illegal command never reaches the ALU; answer directly.
                  rsp_result_d = 32'd0;
                  rsp_error_d  = 2'b11;
                  rsp_valid_d  = 1'b1;
                  state_d      = ST_RESP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == 4'd1) begin
               rsp_result_d = alu_result;
               rsp_error_d  = alu_error;
               rsp_valid_d  = 1'b1;
               cnt_d        = 4'd0;
               state_d      = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
               if (rsp_error_q == 2'b00) begin
                  acc_d = rsp_result_q;
               end else if (err_cnt_q != ERR_MAX) begin
                  err_cnt_d = err_cnt_q + ERR_ONE;
               end else begin
                  err_cnt_d = err_cnt_q;
               end
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         alu_a_q      <= 16'd0;
         alu_b_q      <= 16'd0;
         alu_cmd_q    <= 4'd0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= 32'd0;
         rsp_error_q  <= 2'b00;
         acc_q        <= 32'd0;
         err_cnt_q    <= {ERR_CNT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_cmd_q    <= alu_cmd_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_error_q  <= rsp_error_d;
         acc_q        <= acc_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign req_ready   = (state_q == ST_IDLE) && rst_n;
   assign alu_inputA  = alu_a_q;
   assign alu_inputB  = alu_b_q;
   assign alu_command = alu_cmd_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_error   = rsp_error_q;
   assign acc         = acc_q;
   assign err_count   = err_cnt_q;

endmodule
